serial_sub: RTL and testbench

- Bit-serial subtractor computing a − b − bin over WIDTH clock cycles, LSB first.
- Built around the existing single-bit full-subtractor cell (diff = a^b^bin, borrow = ~a&b | b&bin | ~a&bin), with a registered borrow fed back each cycle.
- Sits between an operand source (start/operand handshake) and a result consumer (done pulse plus held result).
- Trades latency for area compared with a ripple array of full-subtractor cells.

---
 rtl/serial_sub.sv | 153 +++++++++++++++
 tb/tb_serial_sub.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// reusing a single full-subtractor cell with a registered borrow feedback.
// A start request loads the operands. WIDTH edges later a done pulse
// announces the updated diff/borrow_out, which then hold until the next result.

// Single-bit full subtractor: diff = a ^ b ^ bin, borrow = ~a&b | b&bin | ~a&bin.
module full_sub_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic diff_o,
  output logic borrow_o
);
  assign diff_o   = a_i ^ b_i ^ bin_i;
  assign borrow_o = (~a_i & b_i) | (b_i & bin_i) | (~a_i & bin_i);
endmodule

module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // Counter only has to reach WIDTH-1; keep at least one bit for WIDTH=1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             bit_diff;
  logic             bit_borrow;
  logic [WIDTH-1:0] res_shift;

  // The one shared cell operates on the current LSBs and the borrow flop.
  full_sub_cell u_cell (
    .a_i     (a_q[0]),
    .b_i     (b_q[0]),
    .bin_i   (br_q),
    .diff_o  (bit_diff),
    .borrow_o(bit_borrow)
  );

  // Working result with this cycle's difference bit entering at the MSB.
  always_comb begin
    res_shift            = res_q >> 1;
    res_shift[WIDTH-1]   = bit_diff;
  end

  // Next-state and datapath control for the IDLE/RUN sequencer.
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave one
    // unassigned, which would otherwise infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        br_d  = bit_borrow;
        res_d = res_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          diff_d  = res_shift;
          bout_d  = bit_borrow;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: the operand/result shift registers are cleared on reset too, so
    // an aborted operation leaves no stale bits behind.
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = bout_q;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: an 8-bit instance for the main sequences and
// a 1-bit instance for the full-subtractor truth table.
module tb_serial_sub;

  logic       clk = 1'b0;
  logic       rst;

  logic       start8, bin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;

  logic       start1, bin1;
  logic [0:0] a1, b1;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_sub #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .start     (start8),
    .a         (a8),
    .b         (b8),
    .bin       (bin8),
    .busy      (busy8),
    .done      (done8),
    .diff      (diff8),
    .borrow_out(bout8)
  );

  serial_sub #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
    .a         (a1),
    .b         (b1),
    .bin       (bin1),
    .busy      (busy1),
    .done      (done1),
    .diff      (diff1),
    .borrow_out(bout1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one edge on the 8-bit instance; returns just after the accepting edge.
  task automatic start_op8(input logic [7:0] a_v, input logic [7:0] b_v, input logic bin_v);
    a8 = a_v; b8 = b_v; bin8 = bin_v; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    a8 = 8'hAA; b8 = 8'h55; bin8 = 1'b1;  // operands are free to change now
  endtask

  // Count edges until done (bounded), tracking busy and held diff along the way.
  task automatic wait_done8(input logic [7:0] held, output int n,
                            output bit busy_ok, output bit hold_ok);
    n = 0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (n < 20) begin
      tick();
      n++;
      if (done8) break;
      if (busy8 !== 1'b1) busy_ok = 1'b0;
      if (diff8 !== held) hold_ok = 1'b0;
    end
  endtask

  task automatic watch_no_done8(input int cycles, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done8 !== 1'b0) seen = 1'b1;
    end
  endtask

  int  n;
  bit  busy_ok, hold_ok, seen;
  logic [1:0] exp1 [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
  logic [2:0] abc;

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state of both instances.
    check("rst8_outs", 32'({busy8, done8, diff8, bout8}), 32'(0));
    check("rst1_outs", 32'({busy1, done1, diff1, bout1}), 32'(0));

    // 0x5A - 0x3C = 0x1E, 8-cycle latency, busy throughout.
    start_op8(8'h5A, 8'h3C, 1'b0);
    check("t1_busy_accept", 32'(busy8), 32'(1));
    wait_done8(8'h00, n, busy_ok, hold_ok);
    check("t1_latency", 32'(n), 32'(8));
    check("t1_busy_run", 32'(busy_ok), 32'(1));
    check("t1_diff_hold", 32'(hold_ok), 32'(1));
    check("t1_result", 32'({diff8, bout8, busy8}), 32'({8'h1E, 1'b0, 1'b0}));
    tick();
    check("t1_done_pulse", 32'(done8), 32'(0));
    check("t1_result_held", 32'({diff8, bout8}), 32'({8'h1E, 1'b0}));

    // Underflow, then borrow-in cancelling exactly.
    start_op8(8'h00, 8'h01, 1'b0);
    wait_done8(8'h1E, n, busy_ok, hold_ok);
    check("t2a_latency", 32'(n), 32'(8));
    check("t2a_result", 32'({diff8, bout8}), 32'({8'hFF, 1'b1}));
    tick();
    start_op8(8'h80, 8'h7F, 1'b1);
    wait_done8(8'hFF, n, busy_ok, hold_ok);
    check("t2b_hold", 32'(hold_ok), 32'(1));
    check("t2b_result", 32'({diff8, bout8}), 32'({8'h00, 1'b0}));

    // WIDTH=1 truth table, done one cycle after acceptance.
    for (int i = 0; i < 8; i++) begin
      abc = 3'(i);
      a1 = abc[2]; b1 = abc[1]; bin1 = abc[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check($sformatf("w1_busy_%0d", i), 32'({busy1, done1}), 32'({1'b1, 1'b0}));
      tick();
      check($sformatf("w1_res_%0d", i), 32'({done1, busy1, diff1, bout1}),
            32'({1'b1, 1'b0, exp1[i]}));
    end

    // Start while busy is ignored.
    tick();
    start_op8(8'h10, 8'h01, 1'b0);
    tick();
    tick();
    a8 = 8'hFF; b8 = 8'h00; bin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    wait_done8(8'h00, n, busy_ok, hold_ok);
    check("t4_latency_rest", 32'(n), 32'(5));
    check("t4_result", 32'({diff8, bout8}), 32'({8'h0F, 1'b0}));
    watch_no_done8(12, seen);
    check("t4_no_second_done", 32'({seen, busy8}), 32'(0));

    // Reset mid-run discards the operation.
    start_op8(8'h20, 8'h10, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_after_rst", 32'({busy8, done8, diff8, bout8}), 32'(0));
    watch_no_done8(12, seen);
    check("t5_no_done", 32'(seen), 32'(0));
    start_op8(8'h09, 8'h04, 1'b0);
    wait_done8(8'h00, n, busy_ok, hold_ok);
    check("t5_latency", 32'(n), 32'(8));
    check("t5_result", 32'({diff8, bout8}), 32'({8'h05, 1'b0}));

    // Back-to-back: start in the done cycle is accepted.
    tick();
    start_op8(8'h07, 8'h02, 1'b0);
    wait_done8(8'h05, n, busy_ok, hold_ok);
    check("t6a_done", 32'({done8, diff8, bout8}), 32'({1'b1, 8'h05, 1'b0}));
    start_op8(8'h03, 8'h05, 1'b0);
    check("t6_accept", 32'({done8, busy8}), 32'({1'b0, 1'b1}));
    wait_done8(8'h05, n, busy_ok, hold_ok);
    check("t6b_latency", 32'(n), 32'(8));
    check("t6b_hold", 32'({busy_ok, hold_ok}), 32'(3));
    check("t6b_result", 32'({done8, diff8, bout8}), 32'({1'b1, 8'hFE, 1'b1}));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
